// File: rtl/zeroriscy_rf_write_ctrl.sv
// rtl/zeroriscy_rf_write_ctrl.sv - register-file write-port arbiter with load buffer and debug access
//
// Merges ALU writeback, buffered LSU load writeback and debug-unit writes onto
// the single register-file write port, and serves debug register reads.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   alu_we_i/waddr/wdata  zero-latency ALU/CSR writeback (highest priority)
//   lsu_valid_i/ready_o   load writeback handshake; waddr/wdata buffered in a FIFO
//   raddr_a_i/raddr_b_i   ID operand addresses checked against buffered loads
//   hazard_o              an operand address matches a buffered load
//   dbg_req_i/we/addr/wdata  debug access request; dbg_gnt_o pulses on accept
//   dbg_rvalid_o/rdata_o  debug access completion and read data
//   dbg_raddr_o/rdata_i   register-file read port used for debug reads
//   waddr_a_o/wdata_a_o/we_a_o  register-file write port
module zeroriscy_rf_write_ctrl #(
   parameter bit RV32E      = 1'b0,
   parameter int DATA_WIDTH = 32,
   parameter int LSU_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_we_i,
   input  logic [4:0]            alu_waddr_i,
   input  logic [DATA_WIDTH-1:0] alu_wdata_i,
   input  logic                  lsu_valid_i,
   output logic                  lsu_ready_o,
   input  logic [4:0]            lsu_waddr_i,
   input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
   input  logic [4:0]            raddr_a_i,
   input  logic [4:0]            raddr_b_i,
   output logic                  hazard_o,
   input  logic                  dbg_req_i,
   input  logic                  dbg_we_i,
   input  logic [4:0]            dbg_addr_i,
   input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
   output logic                  dbg_gnt_o,
   output logic                  dbg_rvalid_o,
   output logic [DATA_WIDTH-1:0] dbg_rdata_o,
   output logic [4:0]            dbg_raddr_o,
   input  logic [DATA_WIDTH-1:0] dbg_rdata_i,
   output logic [4:0]            waddr_a_o,
   output logic [DATA_WIDTH-1:0] wdata_a_o,
   output logic                  we_a_o
);

   localparam int PW = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, DBG_RD, DBG_WR, RESP} dbg_state_e;

   dbg_state_e            state_q, state_d;
   logic [4:0]            dbg_addr_q;
   logic [DATA_WIDTH-1:0] dbg_wdata_q;
   logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

   logic [4:0]            fifo_addr_q [LSU_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_q [LSU_DEPTH];
   logic [PW-1:0]         wptr_q, rptr_q;
   logic [CW-1:0]         count_q;

   logic                  fifo_empty, fifo_full, push, pop, dbg_commit;
   logic [LSU_DEPTH-1:0]  ent_valid;
   logic                  hit_a, hit_b, hit_dbg, dbg_accept;

   // x0 is hardwired; RV32E has only x0..x15.
   function automatic logic addr_ok(input logic [4:0] a);
      return (a != 5'd0) && !(RV32E && a[4]);
   endfunction

   assign fifo_empty  = (count_q == '0);
   assign fifo_full   = (count_q == CW'(LSU_DEPTH));
   assign lsu_ready_o = !fifo_full;
   assign push        = lsu_valid_i && !fifo_full;

   // An entry is live when its distance from the read pointer is below the count.
   always_comb begin
      hit_a   = 1'b0;
      hit_b   = 1'b0;
      hit_dbg = 1'b0;
      for (int i = 0; i < LSU_DEPTH; i++) begin
         ent_valid[i] = CW'(PW'(i) - rptr_q) < count_q;
         if (ent_valid[i]) begin
            if (fifo_addr_q[i] == raddr_a_i)  hit_a   = 1'b1;
            if (fifo_addr_q[i] == raddr_b_i)  hit_b   = 1'b1;
            if (fifo_addr_q[i] == dbg_addr_q) hit_dbg = 1'b1;
         end
      end
   end

   assign hazard_o = ((raddr_a_i != 5'd0) && hit_a) || ((raddr_b_i != 5'd0) && hit_b);

   // Write-port arbitration: ALU, then FIFO head, then pending debug write.
   // Dropped addresses still consume their source.
   always_comb begin
      pop        = 1'b0;
      dbg_commit = 1'b0;
      we_a_o     = 1'b0;
      waddr_a_o  = 5'd0;
      wdata_a_o  = '0;
      if (!rst_n) begin
         we_a_o = 1'b0;
      end else if (alu_we_i) begin
         waddr_a_o = alu_waddr_i;
         wdata_a_o = alu_wdata_i;
         we_a_o    = addr_ok(alu_waddr_i);
      end else if (!fifo_empty) begin
         pop       = 1'b1;
         waddr_a_o = fifo_addr_q[rptr_q];
         wdata_a_o = fifo_data_q[rptr_q];
         we_a_o    = addr_ok(fifo_addr_q[rptr_q]);
      end else if (state_q == DBG_WR) begin
         dbg_commit = 1'b1;
         waddr_a_o  = dbg_addr_q;
         wdata_a_o  = dbg_wdata_q;
         we_a_o     = addr_ok(dbg_addr_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < LSU_DEPTH; i++) begin
            fifo_addr_q[i] <= 5'd0;
            fifo_data_q[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_addr_q[wptr_q] <= lsu_waddr_i;
            fifo_data_q[wptr_q] <= lsu_wdata_i;
            wptr_q              <= wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   assign dbg_accept = rst_n && (state_q == IDLE) && dbg_req_i;

   always_comb begin
      state_d     = state_q;
      dbg_rdata_d = dbg_rdata_q;
      dbg_gnt_o   = 1'b0;
      case (state_q)
         IDLE: begin
            if (dbg_accept) begin
               dbg_gnt_o = 1'b1;
               state_d   = dbg_we_i ? DBG_WR : DBG_RD;
            end
         end
         DBG_RD: begin
            // Wait until no older write to this register is still in flight.
            if (!((dbg_addr_q != 5'd0) &&
                  (hit_dbg || (alu_we_i && (alu_waddr_i == dbg_addr_q))))) begin
               dbg_rdata_d = (dbg_addr_q == 5'd0) ? '0 : dbg_rdata_i;
               state_d     = RESP;
            end
         end
         DBG_WR: begin
            if (dbg_commit) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         dbg_addr_q  <= 5'd0;
         dbg_wdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         dbg_rdata_q <= dbg_rdata_d;
         if (dbg_accept) begin
            dbg_addr_q  <= dbg_addr_i;
            dbg_wdata_q <= dbg_wdata_i;
         end
      end
   end

   assign dbg_rvalid_o = (state_q == RESP);
   assign dbg_rdata_o  = dbg_rdata_q;
   assign dbg_raddr_o  = dbg_addr_q;

endmodule

// File: tb/tb_zeroriscy_rf_write_ctrl.sv
// tb/tb_zeroriscy_rf_write_ctrl.sv - directed self-checking bench for zeroriscy_rf_write_ctrl
module tb_zeroriscy_rf_write_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_we_i;
   logic [4:0]  alu_waddr_i;
   logic [31:0] alu_wdata_i;
   logic        lsu_valid_i;
   logic        lsu_ready_o;
   logic [4:0]  lsu_waddr_i;
   logic [31:0] lsu_wdata_i;
   logic [4:0]  raddr_a_i;
   logic [4:0]  raddr_b_i;
   logic        hazard_o;
   logic        dbg_req_i;
   logic        dbg_we_i;
   logic [4:0]  dbg_addr_i;
   logic [31:0] dbg_wdata_i;
   logic        dbg_gnt_o;
   logic        dbg_rvalid_o;
   logic [31:0] dbg_rdata_o;
   logic [4:0]  dbg_raddr_o;
   logic [31:0] dbg_rdata_i;
   logic [4:0]  waddr_a_o;
   logic [31:0] wdata_a_o;
   logic        we_a_o;

   logic [31:0] rf_tb [16];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   zeroriscy_rf_write_ctrl #(
      .RV32E      (1'b1),
      .DATA_WIDTH (32),
      .LSU_DEPTH  (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alu_we_i     (alu_we_i),
      .alu_waddr_i  (alu_waddr_i),
      .alu_wdata_i  (alu_wdata_i),
      .lsu_valid_i  (lsu_valid_i),
      .lsu_ready_o  (lsu_ready_o),
      .lsu_waddr_i  (lsu_waddr_i),
      .lsu_wdata_i  (lsu_wdata_i),
      .raddr_a_i    (raddr_a_i),
      .raddr_b_i    (raddr_b_i),
      .hazard_o     (hazard_o),
      .dbg_req_i    (dbg_req_i),
      .dbg_we_i     (dbg_we_i),
      .dbg_addr_i   (dbg_addr_i),
      .dbg_wdata_i  (dbg_wdata_i),
      .dbg_gnt_o    (dbg_gnt_o),
      .dbg_rvalid_o (dbg_rvalid_o),
      .dbg_rdata_o  (dbg_rdata_o),
      .dbg_raddr_o  (dbg_raddr_o),
      .dbg_rdata_i  (dbg_rdata_i),
      .waddr_a_o    (waddr_a_o),
      .wdata_a_o    (wdata_a_o),
      .we_a_o       (we_a_o)
   );

   // Register-file model behind the write port and debug read port.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) rf_tb[i] <= 32'h0;
      end else if (we_a_o) begin
         rf_tb[waddr_a_o[3:0]] <= wdata_a_o;
      end
   end

   assign dbg_rdata_i = rf_tb[dbg_raddr_o[3:0]];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      alu_we_i    = 1'b0;
      alu_waddr_i = 5'd0;
      alu_wdata_i = 32'h0;
      lsu_valid_i = 1'b0;
      lsu_waddr_i = 5'd0;
      lsu_wdata_i = 32'h0;
      raddr_a_i   = 5'd0;
      raddr_b_i   = 5'd0;
      dbg_req_i   = 1'b0;
      dbg_we_i    = 1'b0;
      dbg_addr_i  = 5'd0;
      dbg_wdata_i = 32'h0;
   endtask

   task automatic alu(input logic [4:0] a, input logic [31:0] d);
      alu_we_i    = 1'b1;
      alu_waddr_i = a;
      alu_wdata_i = d;
   endtask

   task automatic lsu(input logic [4:0] a, input logic [31:0] d);
      lsu_valid_i = 1'b1;
      lsu_waddr_i = a;
      lsu_wdata_i = d;
   endtask

   initial begin
      idle_inputs();
      // Reset with an ALU write and a debug request pending.
      rst_n = 1'b0;
      alu(5'd5, 32'hFFFF_FFFF);
      dbg_req_i = 1'b1;
      settle();
      check_eq("rst_we", we_a_o, 0);
      check_eq("rst_waddr", waddr_a_o, 0);
      check_eq("rst_ready", lsu_ready_o, 1);
      check_eq("rst_gnt", dbg_gnt_o, 0);
      check_eq("rst_rvalid", dbg_rvalid_o, 0);
      check_eq("rst_hazard", hazard_o, 0);
      check_eq("rst_raddr", dbg_raddr_o, 0);
      nxt();
      rst_n = 1'b1;
      idle_inputs();
      alu(5'd5, 32'h1234_5678);
      settle();
      check_eq("alu_we", we_a_o, 1);
      check_eq("alu_waddr", waddr_a_o, 5);
      check_eq("alu_wdata", wdata_a_o, 32'h1234_5678);
      nxt();
      idle_inputs();
      settle();
      check_eq("alu_rf_x5", rf_tb[5], 32'h1234_5678);
      check_eq("alu_idle_we", we_a_o, 0);

      // ALU and LSU collide; load commits next cycle.
      nxt();
      alu(5'd3, 32'hA);
      lsu(5'd4, 32'hB);
      raddr_a_i = 5'd4;
      settle();
      check_eq("col_c0_waddr", waddr_a_o, 3);
      check_eq("col_c0_hazard", hazard_o, 0);
      nxt();
      idle_inputs();
      raddr_a_i = 5'd4;
      settle();
      check_eq("col_c1_we", we_a_o, 1);
      check_eq("col_c1_waddr", waddr_a_o, 4);
      check_eq("col_c1_wdata", wdata_a_o, 32'hB);
      check_eq("col_c1_hazard", hazard_o, 1);
      nxt();
      settle();
      check_eq("col_c2_hazard", hazard_o, 0);
      check_eq("col_c2_we", we_a_o, 0);

      // Fill the buffer behind an ALU stream, then drain x7, x8, x9.
      nxt();
      alu(5'd1, 32'h1);
      lsu(5'd7, 32'h70);
      settle();
      check_eq("fill_c0_ready", lsu_ready_o, 1);
      nxt();
      alu(5'd1, 32'h2);
      lsu(5'd8, 32'h80);
      settle();
      check_eq("fill_c1_ready", lsu_ready_o, 1);
      nxt();
      alu(5'd1, 32'h3);
      lsu(5'd9, 32'h90);
      settle();
      check_eq("fill_c2_ready", lsu_ready_o, 0);
      check_eq("fill_c2_waddr", waddr_a_o, 1);
      nxt();
      alu_we_i = 1'b0;
      settle();
      check_eq("drain_c3_ready", lsu_ready_o, 0);
      check_eq("drain_c3_waddr", waddr_a_o, 7);
      check_eq("drain_c3_wdata", wdata_a_o, 32'h70);
      nxt();
      settle();
      check_eq("drain_c4_ready", lsu_ready_o, 1);
      check_eq("drain_c4_waddr", waddr_a_o, 8);
      nxt();
      lsu_valid_i = 1'b0;
      settle();
      check_eq("drain_c5_waddr", waddr_a_o, 9);
      check_eq("drain_c5_wdata", wdata_a_o, 32'h90);
      nxt();
      settle();
      check_eq("drain_c6_we", we_a_o, 0);
      check_eq("drain_c6_ready", lsu_ready_o, 1);
      check_eq("drain_rf_x8", rf_tb[8], 32'h80);

      // Dropped writes: x0 from ALU and LSU, x17 under RV32E.
      nxt();
      alu(5'd0, 32'h1);
      lsu(5'd0, 32'h2);
      settle();
      check_eq("drop_alu_x0", we_a_o, 0);
      nxt();
      idle_inputs();
      lsu(5'd17, 32'h3);
      settle();
      check_eq("drop_lsu_x0", we_a_o, 0);
      check_eq("drop_lsu_x0_waddr", waddr_a_o, 0);
      nxt();
      idle_inputs();
      raddr_b_i = 5'd17;
      settle();
      check_eq("drop_x17_we", we_a_o, 0);
      check_eq("drop_x17_waddr", waddr_a_o, 17);
      check_eq("drop_x17_hazard", hazard_o, 1);
      nxt();
      alu(5'd17, 32'h4);
      settle();
      check_eq("drop_alu_x17", we_a_o, 0);
      check_eq("drop_popped_hazard", hazard_o, 0);
      check_eq("drop_popped_ready", lsu_ready_o, 1);

      // Debug read of x6 waits for the buffered load.
      nxt();
      idle_inputs();
      alu(5'd1, 32'h1);
      lsu(5'd6, 32'hCAFE);
      dbg_req_i  = 1'b1;
      dbg_we_i   = 1'b0;
      dbg_addr_i = 5'd6;
      settle();
      check_eq("dbgrd_gnt", dbg_gnt_o, 1);
      nxt();
      idle_inputs();
      alu(5'd2, 32'h2);
      settle();
      check_eq("dbgrd_c1_gnt", dbg_gnt_o, 0);
      check_eq("dbgrd_c1_raddr", dbg_raddr_o, 6);
      check_eq("dbgrd_c1_rvalid", dbg_rvalid_o, 0);
      nxt();
      alu(5'd3, 32'h3);
      settle();
      check_eq("dbgrd_c2_rvalid", dbg_rvalid_o, 0);
      nxt();
      alu_we_i = 1'b0;
      settle();
      check_eq("dbgrd_c3_waddr", waddr_a_o, 6);
      check_eq("dbgrd_c3_wdata", wdata_a_o, 32'hCAFE);
      check_eq("dbgrd_c3_rvalid", dbg_rvalid_o, 0);
      nxt();
      settle();
      check_eq("dbgrd_c4_rvalid", dbg_rvalid_o, 0);
      nxt();
      settle();
      check_eq("dbgrd_c5_rvalid", dbg_rvalid_o, 1);
      check_eq("dbgrd_c5_rdata", dbg_rdata_o, 32'hCAFE);
      nxt();
      settle();
      check_eq("dbgrd_c6_rvalid", dbg_rvalid_o, 0);
      check_eq("dbgrd_c6_hold", dbg_rdata_o, 32'hCAFE);

      // Debug read of x0 returns zero.
      nxt();
      dbg_req_i  = 1'b1;
      dbg_addr_i = 5'd0;
      settle();
      check_eq("dbgx0_gnt", dbg_gnt_o, 1);
      nxt();
      idle_inputs();
      nxt();
      settle();
      check_eq("dbgx0_rvalid", dbg_rvalid_o, 1);
      check_eq("dbgx0_rdata", dbg_rdata_o, 0);

      // Debug write x10 under a 4-cycle ALU burst.
      nxt();
      alu(5'd1, 32'h11);
      dbg_req_i   = 1'b1;
      dbg_we_i    = 1'b1;
      dbg_addr_i  = 5'd10;
      dbg_wdata_i = 32'hDEAD;
      settle();
      check_eq("dbgwr_gnt", dbg_gnt_o, 1);
      check_eq("dbgwr_c0_waddr", waddr_a_o, 1);
      for (int c = 1; c < 4; c++) begin
         nxt();
         dbg_req_i = 1'b0;
         settle();
         check_eq("dbgwr_burst_waddr", waddr_a_o, 1);
         check_eq("dbgwr_burst_gnt", dbg_gnt_o, 0);
      end
      nxt();
      idle_inputs();
      settle();
      check_eq("dbgwr_c4_we", we_a_o, 1);
      check_eq("dbgwr_c4_waddr", waddr_a_o, 10);
      check_eq("dbgwr_c4_wdata", wdata_a_o, 32'hDEAD);
      check_eq("dbgwr_c4_rvalid", dbg_rvalid_o, 0);
      nxt();
      settle();
      check_eq("dbgwr_c5_rvalid", dbg_rvalid_o, 1);
      check_eq("dbgwr_c5_we", we_a_o, 0);
      nxt();
      settle();
      check_eq("dbgwr_c6_rvalid", dbg_rvalid_o, 0);
      check_eq("dbgwr_rf_x10", rf_tb[10], 32'hDEAD);

      // Reset during DBG_WR with a buffered load: both discarded.
      nxt();
      alu(5'd1, 32'h21);
      lsu(5'd12, 32'h1200);
      dbg_req_i   = 1'b1;
      dbg_we_i    = 1'b1;
      dbg_addr_i  = 5'd11;
      dbg_wdata_i = 32'hBEEF;
      settle();
      check_eq("rstwr_gnt", dbg_gnt_o, 1);
      nxt();
      idle_inputs();
      alu(5'd1, 32'h22);
      raddr_a_i = 5'd12;
      settle();
      check_eq("rstwr_hazard_pre", hazard_o, 1);
      rst_n = 1'b0;
      nxt();
      settle();
      check_eq("rstwr_in_reset_we", we_a_o, 0);
      nxt();
      rst_n    = 1'b1;
      alu_we_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         check_eq("rstwr_post_we", we_a_o, 0);
         check_eq("rstwr_post_rvalid", dbg_rvalid_o, 0);
         check_eq("rstwr_post_hazard", hazard_o, 0);
         nxt();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
